// File: rtl/serial_arith_pkg.sv
// serial_arith_pkg: FSM state encodings shared by the bit-serial arithmetic blocks.
package serial_arith_pkg;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;
endpackage

// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if: operand and result valid/ready channels of the serial subtractor.
interface serial_subtractor_if #(parameter int WIDTH = 4);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_diff;
    logic             out_borrow;
    modport master (output in_valid, in_a, in_b, out_ready,
                    input  in_ready, out_valid, out_diff, out_borrow);
    modport slave  (input  in_valid, in_a, in_b, out_ready,
                    output in_ready, out_valid, out_diff, out_borrow);
endinterface

// File: rtl/serial_subtractor_half.sv
// half_subtractor: one-bit a-b giving difference and borrow-out.
module half_subtractor (
    input  logic a_i,
    input  logic b_i,
    output logic diff_o,
    output logic borrow_o
);
    assign diff_o   = a_i ^ b_i;
    assign borrow_o = ~a_i & b_i;
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: LSB-first bit-serial unsigned A-B with valid/ready handshakes.
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serial_subtractor_if.slave   s
);
    localparam int CW = ($clog2(WIDTH + 1) < 1) ? 1 : $clog2(WIDTH + 1);
    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d, b_sh_q, b_sh_d, res_q, res_d;
    logic             br_q, br_d, ob_q, ob_d;
    logic             d0, b0, d, b1, br_next;
    half_subtractor u_hs0 (.a_i(a_sh_q[0]), .b_i(b_sh_q[0]), .diff_o(d0), .borrow_o(b0));
    half_subtractor u_hs1 (.a_i(d0),        .b_i(br_q),      .diff_o(d),  .borrow_o(b1));
    assign br_next = b0 | b1;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            br_q    <= 1'b0;
            ob_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            br_q    <= br_d;
            ob_q    <= ob_d;
        end
    end
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        res_d   = res_q;
        br_d    = br_q;
        ob_d    = ob_q;
        case (state_q)
            ST_IDLE: if (s.in_valid) begin
                state_d = ST_RUN;
                a_sh_d  = s.in_a;
                b_sh_d  = s.in_b;
                br_d    = 1'b0;
                cnt_d   = '0;
            end
            ST_RUN: begin
                // concatenate-then-shift keeps WIDTH=1 free of reversed slices
                res_d  = WIDTH'({d, res_q} >> 1);
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                br_d   = br_next;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = ST_DONE;
                    ob_d    = br_next;
                end
            end
            ST_DONE: state_d = s.out_ready ? ST_IDLE : ST_DONE;
            default: state_d = ST_IDLE;
        endcase
    end
    assign s.in_ready   = (state_q == ST_IDLE);
    assign s.out_valid  = (state_q == ST_DONE);
    assign s.out_diff   = res_q;
    assign s.out_borrow = ob_q;
endmodule
